// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared constants and state encoding for the CPU-to-RAM access controller
package cpu_mem_pkg;
  localparam int MEM_WORDS      = 512;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_BITS_DEF  = 9;
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_ACC   = 3'd1,
    S_RD_CAP   = 3'd2,
    S_WR_SETUP = 3'd3,
    S_WR_PULSE = 3'd4,
    S_WR_HOLD  = 3'd5,
    S_DONE     = 3'd6
  } state_t;
endpackage

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: latches one read/write request and sequences registered ram strobes with setup/hold
module mem_access_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int ADDR_BITS   = ADDR_BITS_DEF,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  req,
  input  logic                  wr_en,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  addr_err,
  output logic [31:0]           mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);
  state_t                state_q, state_d;
  logic [31:0]           mar_q, mar_d, mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0] mdr_q, mdr_d, rdata_q, rdata_d, mem_data_in_q, mem_data_in_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                  mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic                  out_of_range, wr_phase;
  assign out_of_range = (addr >> ADDR_BITS) != 32'd0;
  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: if (req) begin
        mar_d   = addr;
        mdr_d   = wr_en ? wdata : mdr_q;
        cnt_d   = 4'd0;
        err_d   = out_of_range;
        state_d = out_of_range ? S_DONE : wr_en ? S_WR_SETUP : S_RD_ACC;
      end
      S_RD_ACC: begin
        cnt_d   = cnt_q + 4'd1;
        state_d = (cnt_q == 4'(WAIT_STATES)) ? S_RD_CAP : S_RD_ACC;
      end
      S_RD_CAP: begin
        rdata_d = mem_data_out;
        state_d = S_DONE;
      end
      S_WR_SETUP: state_d = S_WR_PULSE;
      S_WR_PULSE: state_d = S_WR_HOLD;
      S_WR_HOLD:  state_d = S_DONE;
      default:    state_d = S_IDLE;
    endcase
    // outputs are derived from the next state so every strobe leaves a flop
    wr_phase      = state_d inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD};
    busy_d        = state_d != S_IDLE;
    done_d        = state_d == S_DONE;
    mem_read_d    = state_d inside {S_RD_ACC, S_RD_CAP};
    mem_write_d   = state_d == S_WR_PULSE;
    mem_address_d = (mem_read_d || wr_phase) ? mar_d : mem_address_q;
    mem_data_in_d = wr_phase ? mdr_d : mem_data_in_q;
  end
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q       <= S_IDLE;
      mar_q         <= '0;
      mdr_q         <= '0;
      cnt_q         <= '0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
    end else begin
      state_q       <= state_d;
      mar_q         <= mar_d;
      mdr_q         <= mdr_d;
      cnt_q         <= cnt_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign addr_err    = err_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench with a behavioural ram and a word-level reference model
module tb_mem_access_ctrl;
  localparam int WS = 1;
  logic        clock = 1'b0, clear = 1'b0, req = 1'b0, wr_en = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        busy, done, addr_err, mem_read, mem_write;
  logic [31:0] rdata, mem_address, mem_data_in, mem_data_out;
  logic [31:0] ram [0:511];
  logic [31:0] ref_mem [0:511];
  logic [31:0] last_rd = '0;
  typedef struct packed { logic err; logic [31:0] rd; } exp_t;
  exp_t sb[$];
  exp_t e;
  int total = 0, bad = 0, done_cnt = 0;

  mem_access_ctrl #(.DATA_WIDTH(32), .ADDR_BITS(9), .WAIT_STATES(WS)) dut (
    .clock(clock), .clear(clear), .req(req), .wr_en(wr_en), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .addr_err(addr_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_read(mem_read), .mem_write(mem_write), .mem_data_out(mem_data_out)
  );

  always #5 clock = ~clock;

  // ram outputs 0 whenever it is not being read
  assign mem_data_out = mem_read ? ram[mem_address[8:0]] : 32'd0;
  always @(posedge clock) if (mem_write) ram[mem_address[8:0]] <= mem_data_in;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic err;
    err = a >= 32'd512;
    if (!err && wr) ref_mem[a[8:0]] = d;
    if (!err && !wr) last_rd = ref_mem[a[8:0]];
    sb.push_back({err, last_rd});
  endtask

  always @(negedge clock) begin
    if (mem_read && mem_write) chk("strobe_exclusive", 128'(1), 128'(0));
    if (clear && done) begin
      done_cnt++;
      if (sb.size() == 0) chk("unexpected_done", 128'(1), 128'(0));
      else begin
        e = sb.pop_front();
        chk("addr_err", 128'(addr_err), 128'(e.err));
        chk("rdata", 128'(rdata), 128'(e.rd));
      end
    end
  end

  task automatic chk_zero(input string nm);
    chk(nm, 128'({busy, done, addr_err, rdata, mem_address, mem_data_in, mem_read, mem_write}), 128'(0));
  endtask

  // call at a negedge with the controller idle; returns at a negedge with it idle again
  task automatic do_access(input logic wr, input logic [31:0] a, input logic [31:0] d);
    int lat, nrd, nwr, wp, exp_lat;
    logic err, got;
    logic [31:0] ah [0:31];
    logic [31:0] dh [0:31];
    err = a >= 32'd512;
    model_issue(wr, a, d);
    req = 1'b1; wr_en = wr; addr = a; wdata = d;
    @(posedge clock); #1;
    req = 1'b0; addr = $urandom; wdata = $urandom;
    lat = 0; nrd = 0; nwr = 0; wp = 0; got = 1'b0;
    for (int i = 1; i <= 30 && !got; i++) begin
      @(negedge clock);
      ah[i] = mem_address; dh[i] = mem_data_in;
      nrd += int'(mem_read); nwr += int'(mem_write);
      if (mem_write) wp = i;
      if (done) begin got = 1'b1; lat = i; end
    end
    if (!got) chk("done_timeout", 128'(0), 128'(1));
    else begin
      exp_lat = err ? 1 : wr ? 4 : WS + 3;
      chk("latency", 128'(lat), 128'(exp_lat));
      chk("read_strobe_cycles", 128'(nrd), 128'((err || wr) ? 0 : WS + 2));
      chk("write_strobe_cycles", 128'(nwr), 128'((wr && !err) ? 1 : 0));
      if (wr && !err && wp > 1)
        chk("write_addr_data_stable", {32'd0, ah[wp-1], ah[wp+1], dh[wp]}, {32'd0, a, a, d});
    end
    @(negedge clock);
  endtask

  initial begin
    int nd, bl, prevd, d0;
    for (int i = 0; i < 512; i++) begin ram[i] = '0; ref_mem[i] = '0; end
    ram[43] = 32'h2; ref_mem[43] = 32'h2;
    ram[95] = 32'hD; ref_mem[95] = 32'hD;
    #1 chk_zero("reset_state");
    @(negedge clock); @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    chk_zero("idle_after_reset");

    do_access(1'b0, 32'h2B, 32'h0);
    do_access(1'b1, 32'h87, 32'hDEADBEEF);
    do_access(1'b0, 32'h87, 32'h0);
    do_access(1'b0, 32'h2B, 32'h0);
    do_access(1'b0, 32'h200, 32'h0);
    chk("rdata_after_err", 128'(rdata), 128'(32'h2));

    // a second request pulsed mid-read must be dropped
    d0 = done_cnt;
    model_issue(1'b0, 32'h5F, 32'h0);
    req = 1'b1; wr_en = 1'b0; addr = 32'h5F;
    @(posedge clock); #1 req = 1'b0;
    @(posedge clock); #1 req = 1'b1; addr = 32'h2B;
    @(posedge clock); #1 req = 1'b0;
    repeat (10) @(negedge clock);
    chk("busy_req_ignored", 128'(done_cnt - d0), 128'(1));

    // reset during the write pulse abandons the access before ram is written
    req = 1'b1; wr_en = 1'b1; addr = 32'h10; wdata = 32'h12345678;
    @(posedge clock); #1 req = 1'b0;
    for (int i = 0; i < 10 && !mem_write; i++) @(negedge clock);
    chk("write_pulse_seen", 128'(mem_write), 128'(1));
    #2 clear = 1'b0;
    #1 chk_zero("async_reset_mid_write");
    last_rd = '0;
    @(negedge clock); clear = 1'b1;
    @(negedge clock);
    do_access(1'b0, 32'h2B, 32'h0);
    do_access(1'b0, 32'h10, 32'h0);

    // continuous req: back-to-back reads
    for (int k = 0; k < 4; k++) model_issue(1'b0, 32'h2B, 32'h0);
    req = 1'b1; wr_en = 1'b0; addr = 32'h2B;
    nd = 0; bl = 0; prevd = 0;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clock);
      if (done) begin
        if (nd > 0) chk("b2b_period", 128'(n - prevd), 128'(5));
        prevd = n; nd++;
      end
      if (n <= 19 && !busy) bl++;
      if (n == 20) req = 1'b0;
    end
    chk("b2b_done_count", 128'(nd), 128'(4));
    chk("b2b_busy_low_cycles", 128'(bl), 128'(3));

    for (int k = 0; k < 60; k++) begin
      logic [31:0] a;
      int r;
      r = $urandom_range(0, 9);
      a = (r == 0) ? 32'h200 + $urandom_range(0, 1000) : (r == 1) ? $urandom : $urandom_range(0, 511);
      do_access(1'($urandom_range(0, 1)), a, $urandom);
    end

    repeat (3) @(negedge clock);
    chk("scoreboard_drained", 128'(sb.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
